// File: rtl/alu_seq_pkg.sv
// Shared opcode and state encodings for the nibble-serial ALU controller.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ROTL = 3'b110;
  localparam logic [2:0] OP_ROTR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_fixup.sv
// Boundary-bit patch for shift/rotate passes: the 4-bit ALU cannot see the
// bit that crosses between nibbles, so it is inserted here from the operand.
module alu_seq_fixup
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic       pass_hi,
  input  logic [7:0] a,
  input  logic [3:0] alu_output,
  output logic [3:0] nibble
);

  always_comb begin
    nibble = alu_output;
    if (!pass_hi) begin
      unique case (op)
        OP_SHR, OP_ROTR: nibble[3] = a[4];
        OP_ROTL:         nibble[0] = a[7];
        default:         nibble    = alu_output;
      endcase
    end else begin
      unique case (op)
        OP_SHL, OP_ROTL: nibble[0] = a[3];
        OP_ROTR:         nibble[3] = a[0];
        default:         nibble    = alu_output;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Runs one 8-bit operation as two passes (low nibble, then high nibble)
// through an external 4-bit ALU, with valid/ready request and response.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// LO    | low-nibble pass on the ALU, carry captured
// HI    | high-nibble pass on the ALU, rsp_cout resolved
// DONE  | rsp_valid high, result held until rsp_ready
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_cin,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_control,
  input  logic [3:0] alu_output,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_cout
);

  state_t     state, state_nxt;
  logic [2:0] op_r;
  logic [7:0] a_r, b_r, res_r;
  logic       cin_r, carry_r, cout_r;
  logic       is_arith;
  logic [3:0] fixed_nibble;

  assign is_arith   = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign rsp_result = res_r;
  assign rsp_cout   = cout_r;

  alu_seq_fixup u_fixup (
    .op         (op_r),
    .pass_hi    (state == HI),
    .a          (a_r),
    .alu_output (alu_output),
    .nibble     (fixed_nibble)
  );

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_a       = 4'h0;
    alu_b       = 4'h0;
    alu_cin     = 1'b0;
    alu_control = 3'b000;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LO;
      end
      LO: begin
        alu_a       = a_r[3:0];
        alu_b       = b_r[3:0];
        alu_cin     = is_arith ? cin_r : 1'b0;
        alu_control = op_r;
        state_nxt   = HI;
      end
      HI: begin
        alu_a       = a_r[7:4];
        alu_b       = b_r[7:4];
        alu_cin     = is_arith ? carry_r : 1'b0;
        alu_control = op_r;
        state_nxt   = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= 3'b000;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      cin_r   <= 1'b0;
      carry_r <= 1'b0;
      res_r   <= 8'h00;
      cout_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (req_valid) begin
          op_r  <= req_op;
          a_r   <= req_a;
          b_r   <= req_b;
          cin_r <= req_cin;
        end
        LO: begin
          res_r[3:0] <= fixed_nibble;
          carry_r    <= alu_cout;
        end
        HI: begin
          res_r[7:4] <= fixed_nibble;
          // Shifts report the bit that left the byte; logic ops have none.
          unique case (op_r)
            OP_ADD, OP_SUB:   cout_r <= alu_cout;
            OP_SHL, OP_ROTL:  cout_r <= a_r[7];
            OP_SHR, OP_ROTR:  cout_r <= a_r[0];
            default:          cout_r <= 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a nibble ALU, an 8-bit reference model checked
// every cycle, and directed operations with literal expected results.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_cin;
  logic [2:0] req_op;
  logic [7:0] req_a, req_b;
  logic [3:0] alu_a, alu_b, alu_output;
  logic       alu_cin, alu_cout;
  logic [2:0] alu_control;
  logic       rsp_valid, rsp_ready, rsp_cout;
  logic [7:0] rsp_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_control(alu_control),
    .alu_output(alu_output), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout)
  );

  // The shared 4-bit ALU: shifts and rotates stay inside the nibble.
  always_comb begin
    logic [4:0] wide;
    wide       = 5'h00;
    alu_output = 4'h0;
    alu_cout   = 1'b0;
    case (alu_control)
      3'b000: begin wide = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
                    alu_output = wide[3:0]; alu_cout = wide[4]; end
      3'b001: begin wide = {1'b0, alu_a} - {1'b0, alu_b} - 5'(alu_cin);
                    alu_output = wide[3:0]; alu_cout = wide[4]; end
      3'b010: alu_output = alu_a | alu_b;
      3'b011: alu_output = alu_a & alu_b;
      3'b100: alu_output = {alu_a[2:0], 1'b0};
      3'b101: alu_output = {1'b0, alu_a[3:1]};
      3'b110: alu_output = {alu_a[2:0], alu_a[3]};
      default: alu_output = {alu_a[0], alu_a[3:1]};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-byte reference: {carry/borrow or shifted-out bit, result}.
  function automatic logic [8:0] golden(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b} + 9'(cin);
      3'd1: return {1'b0, a} - {1'b0, b} - 9'(cin);
      3'd2: return {1'b0, a | b};
      3'd3: return {1'b0, a & b};
      3'd4: return {a[7], a[6:0], 1'b0};
      3'd5: return {a[0], 1'b0, a[7:1]};
      3'd6: return {a[7], a[6:0], a[7]};
      default: return {a[0], a[0], a[7:1]};
    endcase
  endfunction

  // Model: cycles since acceptance (0 = idle, 3 = holding a response).
  int         m_phase;
  logic [2:0] m_op;
  logic [7:0] m_a, m_b, m_res;
  logic       m_cin, m_cout, m_locarry;

  always @(posedge clk or posedge rst) begin
    logic [8:0] g;
    if (rst) begin
      m_phase = 0; m_res = 8'h00; m_cout = 1'b0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_phase = 1; m_op = req_op; m_a = req_a; m_b = req_b; m_cin = req_cin;
          if (req_op == 3'd0) m_locarry = (5'(req_a[3:0]) + 5'(req_b[3:0]) + 5'(req_cin)) > 5'd15;
          else                m_locarry = 5'(req_a[3:0]) < (5'(req_b[3:0]) + 5'(req_cin));
        end
        1: m_phase = 2;
        2: begin
          m_phase = 3;
          g = golden(m_op, m_a, m_b, m_cin);
          m_res = g[7:0]; m_cout = g[8];
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic arith;
    if (!rst) begin
      arith = (m_op == 3'd0) || (m_op == 3'd1);
      check("req_ready", 32'(req_ready), 32'(m_phase == 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 3));
      if (m_phase == 3) begin
        check("rsp_result", 32'(rsp_result), 32'(m_res));
        check("rsp_cout", 32'(rsp_cout), 32'(m_cout));
      end
      case (m_phase)
        1: begin
          check("alu_a_lo", 32'(alu_a), 32'(m_a[3:0]));
          check("alu_b_lo", 32'(alu_b), 32'(m_b[3:0]));
          check("alu_cin_lo", 32'(alu_cin), 32'(arith ? m_cin : 1'b0));
          check("alu_ctl_lo", 32'(alu_control), 32'(m_op));
        end
        2: begin
          check("alu_a_hi", 32'(alu_a), 32'(m_a[7:4]));
          check("alu_b_hi", 32'(alu_b), 32'(m_b[7:4]));
          check("alu_cin_hi", 32'(alu_cin), 32'(arith ? m_locarry : 1'b0));
          check("alu_ctl_hi", 32'(alu_control), 32'(m_op));
        end
        default:
          check("alu_idle", 32'({alu_a, alu_b, alu_cin, alu_control}), 32'h0);
      endcase
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("req_ready_timeout", 32'(req_ready), 32'h1);
  endtask

  task automatic wait_valid(output int edges);
    edges = 1;
    while (!rsp_valid && edges < 12) begin @(posedge clk); #1; edges++; end
  endtask

  // Issue one request and wait for its response; rsp_ready is left as set.
  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        input logic [7:0] er, input logic ec);
    int edges;
    wait_ready();
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid(edges);
    check({name, "_latency"}, 32'(edges), 32'd3);
    check({name, "_result"}, 32'(rsp_result), 32'(er));
    check({name, "_cout"}, 32'(rsp_cout), 32'(ec));
    check({name, "_model"}, 32'({m_cout, m_res}), 32'({ec, er}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 8'h00; req_b = 8'h00;
    req_cin = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'({rsp_valid, rsp_result, rsp_cout, alu_a, alu_b, alu_cin, alu_control}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);

    run_op("add",    3'd0, 8'h8F, 8'h71, 1'b0, 8'h00, 1'b1);
    run_op("sub1",   3'd1, 8'h30, 8'h01, 1'b0, 8'h2F, 1'b0);
    run_op("sub2",   3'd1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("addcin", 3'd0, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0);
    run_op("subbin", 3'd1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    run_op("or",     3'd2, 8'hA5, 8'h5A, 1'b1, 8'hFF, 1'b0);
    run_op("and",    3'd3, 8'hA5, 8'h5A, 1'b0, 8'h00, 1'b0);
    run_op("shl",    3'd4, 8'h96, 8'h00, 1'b0, 8'h2C, 1'b1);
    run_op("shr",    3'd5, 8'h96, 8'h00, 1'b0, 8'h4B, 1'b0);
    run_op("rotl",   3'd6, 8'h81, 8'h00, 1'b0, 8'h03, 1'b1);
    run_op("rotr",   3'd7, 8'h81, 8'h00, 1'b0, 8'hC0, 1'b1);

    // Backpressure: a pending request must wait out the held response.
    wait_ready();
    rsp_ready = 1'b0;
    run_op("bp", 3'd0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    req_valid = 1'b1; req_op = 3'd1; req_a = 8'h10; req_b = 8'h01; req_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", 32'({rsp_valid, req_ready, rsp_result, rsp_cout}), 32'({1'b1, 1'b0, 8'h46, 1'b0}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'({rsp_valid, req_ready}), 32'b01);
    @(posedge clk); #1;
    check("bp_accept", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    wait_valid(edges);
    check("bp_second", 32'({rsp_cout, rsp_result}), 32'({1'b0, 8'h0F}));

    // Reset while the high nibble is on the ALU.
    wait_ready();
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'h3C; req_b = 8'h5A; req_cin = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_hi_alu_a", 32'(alu_a), 32'h3);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'({rsp_valid, rsp_result, rsp_cout, alu_a, alu_b, alu_cin, alu_control}), 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'({req_ready, rsp_valid}), 32'b10);
    run_op("post_rst_add", 3'd0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
